// File: rtl/simon_result_pkt_tx.sv
// Response packetiser: captures a finished SIMON block and tag, then streams
// RSP_HDR, tag and the data bytes over a byte-wide valid/ready port.
module simon_result_pkt_tx #(
    parameter int unsigned N       = 16,
    parameter logic [7:0]  RSP_HDR = 8'hA0
) (
    input  logic                  clk,
    input  logic                  R,
    input  logic                  donePkt,
    input  logic [7:0]            tagIn,
    input  logic [1:0][N-1:0]     outData,
    output logic [7:0]            txByte,
    output logic                  txValid,
    input  logic                  txReady,
    output logic                  txLast,
    output logic                  busy,
    output logic                  ovf
);

    localparam int unsigned NB = N / 4;
    localparam int unsigned CW = $clog2(NB);
    localparam int unsigned W2 = 2 * N;

    typedef enum logic [1:0] {IDLE, HDR, TAG, DATA} state_t;

    state_t          state, stateNext;
    logic [CW-1:0]   cnt, cntNext;
    logic [W2-1:0]   actData, actDataNext;
    logic [7:0]      actTag, actTagNext;
    logic [W2-1:0]   pendData, pendDataNext;
    logic [7:0]      pendTag, pendTagNext;
    logic            pendFull, pendFullNext;
    logic            ovfNext;
    logic [7:0]      txByteNext;
    logic            txValidNext, txLastNext, busyNext;
    logic            beat, lastBeat;
    logic [W2-1:0]   shifted;
    int unsigned     byteShift;

    assign beat     = txValid && txReady;
    assign lastBeat = beat && (state == DATA) && (cnt == CW'(NB - 1));

    // Next state plus the registered output values that go with it
    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        actDataNext  = actData;
        actTagNext   = actTag;
        pendDataNext = pendData;
        pendTagNext  = pendTag;
        pendFullNext = pendFull;
        ovfNext      = ovf;
        txByteNext   = 8'h00;
        shifted      = '0;
        byteShift    = 0;

        unique case (state)
            IDLE: begin
                if (donePkt) begin
                    actDataNext = outData;
                    actTagNext  = tagIn;
                    cntNext     = '0;
                    stateNext   = HDR;
                end
            end
            HDR: begin
                if (beat) stateNext = TAG;
            end
            TAG: begin
                if (beat) begin
                    stateNext = DATA;
                    cntNext   = '0;
                end
            end
            DATA: begin
                if (lastBeat) begin
                    cntNext = '0;
                    if (pendFull) begin
                        actDataNext  = pendData;
                        actTagNext   = pendTag;
                        stateNext    = HDR;
                        pendFullNext = 1'b0;
                        if (donePkt) begin
                            pendDataNext = outData;
                            pendTagNext  = tagIn;
                            pendFullNext = 1'b1;
                        end
                    end else if (donePkt) begin
                        actDataNext = outData;
                        actTagNext  = tagIn;
                        stateNext   = HDR;
                    end else begin
                        stateNext = IDLE;
                    end
                end else if (beat) begin
                    cntNext = cnt + CW'(1);
                end
            end
            default: stateNext = IDLE;
        endcase

        // Mid-packet arrivals go to the pending slot, or are dropped when it is taken
        if (donePkt && (state != IDLE) && !lastBeat) begin
            if (!pendFull) begin
                pendDataNext = outData;
                pendTagNext  = tagIn;
                pendFullNext = 1'b1;
            end else begin
                ovfNext = 1'b1;
            end
        end

        byteShift = 8 * (NB - 1 - 32'(cntNext));
        shifted   = actDataNext >> byteShift;

        unique case (stateNext)
            HDR:     txByteNext = RSP_HDR;
            TAG:     txByteNext = actTagNext;
            DATA:    txByteNext = shifted[7:0];
            default: txByteNext = 8'h00;
        endcase

        txValidNext = (stateNext != IDLE);
        txLastNext  = (stateNext == DATA) && (cntNext == CW'(NB - 1));
        busyNext    = (stateNext != IDLE) || pendFullNext;
    end

    always_ff @(posedge clk) begin
        if (R) begin
            state    <= IDLE;
            cnt      <= '0;
            actData  <= '0;
            actTag   <= 8'h00;
            pendData <= '0;
            pendTag  <= 8'h00;
            pendFull <= 1'b0;
            ovf      <= 1'b0;
            txByte   <= 8'h00;
            txValid  <= 1'b0;
            txLast   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            actData  <= actDataNext;
            actTag   <= actTagNext;
            pendData <= pendDataNext;
            pendTag  <= pendTagNext;
            pendFull <= pendFullNext;
            ovf      <= ovfNext;
            txByte   <= txByteNext;
            txValid  <= txValidNext;
            txLast   <= txLastNext;
            busy     <= busyNext;
        end
    end

endmodule

// File: tb/tb_simon_result_pkt_tx.sv
// Bench for simon_result_pkt_tx: directed scenarios plus random traffic on N=16
// and N=32 instances, checked against a byte-queue packet model.
module tb_simon_result_pkt_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             R, donePkt, txReady;
    logic [7:0]       tagIn;
    logic [1:0][15:0] outDataA;
    logic [1:0][31:0] outDataB;
    logic [7:0]       txByteA, txByteB;
    logic             txValidA, txValidB, txLastA, txLastB;
    logic             busyA, busyB, ovfA, ovfB;

    simon_result_pkt_tx #(.N(16), .RSP_HDR(8'hA0)) dutA (
        .clk(clk), .R(R), .donePkt(donePkt), .tagIn(tagIn), .outData(outDataA),
        .txByte(txByteA), .txValid(txValidA), .txReady(txReady), .txLast(txLastA),
        .busy(busyA), .ovf(ovfA)
    );

    simon_result_pkt_tx #(.N(32), .RSP_HDR(8'hA0)) dutB (
        .clk(clk), .R(R), .donePkt(donePkt), .tagIn(tagIn), .outData(outDataB),
        .txByte(txByteB), .txValid(txValidB), .txReady(txReady), .txLast(txLastB),
        .busy(busyB), .ovf(ovfB)
    );

    int checks = 0;
    int errors = 0;
    bit sel = 1'b0;   // 0: N=16 instance is modelled, 1: N=32 instance

    // Model: bytes still to send for the active packet, plus one pending packet
    logic [7:0] curQ[$];
    logic [7:0] pendQ[$];
    logic [7:0] newQ[$];
    bit         pendV;
    bit         ovfM;

    function automatic void buildPkt(input logic [7:0] tag, input logic [63:0] w1, input logic [63:0] w0);
        int n;
        n = sel ? 32 : 16;
        newQ = {};
        newQ.push_back(8'hA0);
        newQ.push_back(tag);
        for (int i = n / 8 - 1; i >= 0; i--) newQ.push_back(w1[8*i +: 8]);
        for (int i = n / 8 - 1; i >= 0; i--) newQ.push_back(w0[8*i +: 8]);
    endfunction

    function automatic void modelStep(input bit done, input logic [7:0] tag, input logic [63:0] w1,
                                      input logic [63:0] w0, input bit rdy, input bit rst);
        if (rst) begin
            curQ = {}; pendQ = {}; pendV = 1'b0; ovfM = 1'b0;
            return;
        end
        if (curQ.size() > 0 && rdy) begin
            void'(curQ.pop_front());
            if (curQ.size() == 0 && pendV) begin
                curQ  = pendQ;
                pendV = 1'b0;
            end
        end
        if (done) begin
            buildPkt(tag, w1, w0);
            if (curQ.size() == 0) curQ = newQ;
            else if (!pendV) begin pendQ = newQ; pendV = 1'b1; end
            else ovfM = 1'b1;
        end
    endfunction

    function automatic logic [11:0] expVec();
        logic v;
        v = (curQ.size() > 0);
        return {v, curQ.size() == 1, v || pendV, ovfM, v ? curQ[0] : 8'h00};
    endfunction

    function automatic logic [11:0] obsVec();
        if (sel) return {txValidB, txLastB, busyB, ovfB, txValidB ? txByteB : 8'h00};
        return {txValidA, txLastA, busyA, ovfA, txValidA ? txByteA : 8'h00};
    endfunction

    task automatic cycle(input bit done, input logic [7:0] tag, input logic [63:0] w1,
                         input logic [63:0] w0, input bit rdy, input bit rst);
        donePkt     = done;
        tagIn       = tag;
        outDataA[1] = w1[15:0];
        outDataA[0] = w0[15:0];
        outDataB[1] = w1[31:0];
        outDataB[0] = w0[31:0];
        txReady     = rdy;
        R           = rst;
        @(posedge clk);
        modelStep(done, tag, w1, w0, rdy, rst);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 8'h55, 64'h1111, 64'h2222, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 64'h0, 64'h0, 1'b1, 1'b1);
        checks++;
        if ({txByteA, txValidA, txLastA, busyA, ovfA} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state got byte=%h v=%b l=%b busy=%b ovf=%b want all zero",
                     txByteA, txValidA, txLastA, busyA, ovfA);
        end
        cycle(1'b0, 8'h00, 64'h0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic test_basic();
        logic [7:0] exp6 [6] = '{8'hA0, 8'h01, 8'hC6, 8'h9B, 8'hE9, 8'hBB};
        for (int k = 0; k < 7; k++) begin
            cycle(k == 0, 8'h01, 64'hC69B, 64'hE9BB, 1'b1, 1'b0);
            checks++;
            if (k < 6 && {txValidA, txLastA, busyA, txByteA} !== {1'b1, k == 5, 1'b1, exp6[k]}) begin
                errors++;
                $display("FAIL basic_byte%0d got v=%b l=%b busy=%b byte=%h want byte=%h", k,
                         txValidA, txLastA, busyA, txByteA, exp6[k]);
            end
            if (k == 6 && {txValidA, busyA} !== 2'b00) begin
                errors++;
                $display("FAIL basic_idle got v=%b busy=%b want 0 0", txValidA, busyA);
            end
            checks++;
            if (obsVec() !== expVec()) begin
                errors++;
                $display("FAIL basic_model cyc%0d got %h want %h", k, obsVec(), expVec());
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp6 [6] = '{8'hA0, 8'h01, 8'hC6, 8'h9B, 8'hE9, 8'hBB};
        logic [7:0] acc[$];
        int i = 0;
        cycle(1'b1, 8'h01, 64'hC69B, 64'hE9BB, 1'b0, 1'b0);
        while (acc.size() < 6 && i < 40) begin
            bit rdy;
            rdy = (i % 3 == 0);
            if (txValidA && rdy) acc.push_back(txByteA);
            cycle(1'b0, 8'h00, 64'h0, 64'h0, rdy, 1'b0);
            checks++;
            if (obsVec() !== expVec()) begin
                errors++;
                $display("FAIL stall_model cyc%0d got %h want %h", i, obsVec(), expVec());
            end
            i++;
        end
        checks++;
        if (acc.size() != 6) begin
            errors++;
            $display("FAIL stall_beats got %0d want 6", acc.size());
        end
        for (int j = 0; j < acc.size() && j < 6; j++) begin
            checks++;
            if (acc[j] !== exp6[j]) begin
                errors++;
                $display("FAIL stall_order beat%0d got %h want %h", j, acc[j], exp6[j]);
            end
        end
        checks++;
        if (txValidA !== 1'b0) begin
            errors++;
            $display("FAIL stall_extra_beat got v=%b want 0", txValidA);
        end
    endtask

    // Second block during C6; with dropThird a third block arrives while both slots are full
    task automatic run_two_pkts(input bit dropThird);
        logic [7:0] exp12 [12] = '{8'hA0, 8'h01, 8'hC6, 8'h9B, 8'hE9, 8'hBB,
                                   8'hA0, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
        for (int k = 0; k < 14; k++) begin
            if (k == 0)                  cycle(1'b1, 8'h01, 64'hC69B, 64'hE9BB, 1'b1, 1'b0);
            else if (k == 3)             cycle(1'b1, 8'h02, 64'h1234, 64'h5678, 1'b1, 1'b0);
            else if (k == 4 && dropThird) cycle(1'b1, 8'h03, 64'hDEAD, 64'hBEEF, 1'b1, 1'b0);
            else                         cycle(1'b0, 8'h00, 64'h0, 64'h0, 1'b1, 1'b0);
            checks++;
            if (k < 12 && {txValidA, txLastA, busyA, txByteA} !==
                {1'b1, (k == 5 || k == 11), 1'b1, exp12[k]}) begin
                errors++;
                $display("FAIL b2b%0d_byte%0d got v=%b l=%b busy=%b byte=%h want byte=%h",
                         dropThird, k, txValidA, txLastA, busyA, txByteA, exp12[k]);
            end
            if (k >= 12 && {txValidA, busyA} !== 2'b00) begin
                errors++;
                $display("FAIL b2b%0d_idle got v=%b busy=%b want 0 0", dropThird, txValidA, busyA);
            end
            checks++;
            if (ovfA !== (dropThird && k >= 4)) begin
                errors++;
                $display("FAIL b2b%0d_ovf cyc%0d got %b want %b", dropThird, k, ovfA, dropThird && k >= 4);
            end
            checks++;
            if (obsVec() !== expVec()) begin
                errors++;
                $display("FAIL b2b%0d_model cyc%0d got %h want %h", dropThird, k, obsVec(), expVec());
            end
        end
    endtask

    task automatic test_back_to_back();
        run_two_pkts(1'b0);
    endtask

    task automatic test_overflow();
        run_two_pkts(1'b1);
    endtask

    task automatic test_reset_midpacket();
        logic [7:0] exp6 [6] = '{8'hA0, 8'h05, 8'hBE, 8'hEF, 8'h01, 8'h02};
        cycle(1'b1, 8'h01, 64'hC69B, 64'hE9BB, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 64'h0, 64'h0, 1'b1, 1'b0);
        checks++;
        if (txByteA !== 8'h9B) begin
            errors++;
            $display("FAIL rstmid_pre got %h want 9b", txByteA);
        end
        cycle(1'b1, 8'h77, 64'h4444, 64'h5555, 1'b1, 1'b1);
        checks++;
        if ({txValidA, busyA, ovfA} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_clear got v=%b busy=%b ovf=%b want 0 0 0", txValidA, busyA, ovfA);
        end
        for (int k = 0; k < 7; k++) begin
            cycle(k == 0, 8'h05, 64'hBEEF, 64'h0102, 1'b1, 1'b0);
            checks++;
            if (k < 6 && {txValidA, txLastA, txByteA} !== {1'b1, k == 5, exp6[k]}) begin
                errors++;
                $display("FAIL rstmid_pkt byte%0d got v=%b l=%b byte=%h want %h", k,
                         txValidA, txLastA, txByteA, exp6[k]);
            end
            if (k == 6 && txValidA !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_tail got v=%b want 0", txValidA);
            end
        end
    endtask

    task automatic test_wide();
        logic [7:0] exp10 [10] = '{8'hA0, 8'h66, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                                   8'h00, 8'h11, 8'h22, 8'h33};
        sel = 1'b1;
        cycle(1'b0, 8'h00, 64'h0, 64'h0, 1'b1, 1'b1);
        for (int k = 0; k < 11; k++) begin
            cycle(k == 0, 8'h66, 64'hAABBCCDD, 64'h00112233, 1'b1, 1'b0);
            checks++;
            if (k < 10 && {txValidB, txLastB, txByteB} !== {1'b1, k == 9, exp10[k]}) begin
                errors++;
                $display("FAIL wide byte%0d got v=%b l=%b byte=%h want %h", k,
                         txValidB, txLastB, txByteB, exp10[k]);
            end
            if (k == 10 && {txValidB, busyB} !== 2'b00) begin
                errors++;
                $display("FAIL wide_idle got v=%b busy=%b want 0 0", txValidB, busyB);
            end
        end
    endtask

    task automatic test_random(input bit wide, input int cycles);
        sel = wide;
        cycle(1'b0, 8'h00, 64'h0, 64'h0, 1'b1, 1'b1);
        for (int i = 0; i < cycles; i++) begin
            bit done, rdy, rst;
            done = ($urandom_range(0, 3) == 0);
            rdy  = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 199) == 0);
            cycle(done, 8'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, rdy, rst);
            checks++;
            if (obsVec() !== expVec()) begin
                errors++;
                $display("FAIL random_n%0d cyc%0d got %h want %h", wide ? 32 : 16, i, obsVec(), expVec());
            end
        end
    endtask

    initial begin
        R = 1'b1; donePkt = 1'b0; tagIn = 8'h00; txReady = 1'b1;
        outDataA = '0; outDataB = '0;
        pendV = 1'b0; ovfM = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_overflow();
        test_reset_midpacket();
        test_wide();
        test_random(1'b0, 2000);
        test_random(1'b1, 1000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
